// File: rtl/fb_slave_tx_statem_if.sv
// Outbound FreeDM slave transmit port bundle: frame request, FWFT payload source and PHY nibble side.
// TxCrcErr exists only when FB_TX_CRC_INJECT_EN is defined.
interface fb_slave_tx_statem_if;
  // Handshakes: TxStart is accepted only at an edge where the framer is idle and TxAbort is low.
  // TxType and TxNibLen are captured at that same edge. TxNibRd is a consume strobe on an
  // always-ready FWFT source, so TxData must be valid in every cycle that TxNibRd is high.
  // TxBusy is high from the accepted start through the end of the gap.
  logic        TxStart;
  logic [2:0]  TxType;
  logic [11:0] TxNibLen;
  logic        TxAbort;
  logic [3:0]  TxData;
  logic        TxNibRd;
  logic [3:0]  MTxD;
  logic        MTxEn;
  logic        TxBusy;
  logic        TxDone;
  logic [5:0]  state_dbg;
`ifdef FB_TX_CRC_INJECT_EN
  logic        TxCrcErr;
`endif

  modport master (
    output TxStart, TxType, TxNibLen, TxAbort, TxData,
`ifdef FB_TX_CRC_INJECT_EN
    output TxCrcErr,
`endif
    input  TxNibRd, MTxD, MTxEn, TxBusy, TxDone, state_dbg
  );

  modport slave (
    input  TxStart, TxType, TxNibLen, TxAbort, TxData,
`ifdef FB_TX_CRC_INJECT_EN
    input  TxCrcErr,
`endif
    output TxNibRd, MTxD, MTxEn, TxBusy, TxDone, state_dbg
  );
endinterface

// File: rtl/fb_slave_tx_statem.sv
// FreeDM slave transmit framer: preamble, SoC, FWFT payload, CRC-8 (0x07), inter-frame gap.
// Optional macro FB_TX_CRC_INJECT_EN adds TxCrcErr to invert both transmitted CRC nibbles.
module fb_slave_tx_statem #(
  parameter int unsigned PREAMBLE_NIBS = 7,
  parameter int unsigned IFG_NIBS      = 4,
  parameter logic [3:0]  SOC_DATA      = 4'hD,
  parameter logic [3:0]  SOC_NUMB      = 4'h9,
  parameter logic [3:0]  SOC_DIST      = 4'hB,
  parameter logic [3:0]  SOC_DELAY     = 4'h7,
  parameter logic [3:0]  SOC_DELAYDIST = 4'h3
) (
  input logic                 MRxClk,
  input logic                 Reset,
  fb_slave_tx_statem_if.slave bus
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_PRE  = 6'b000010,
    S_SOC  = 6'b000100,
    S_DATA = 6'b001000,
    S_CRC  = 6'b010000,
    S_IFG  = 6'b100000
  } state_t;

  localparam logic [11:0] PRE_LOAD = 12'(PREAMBLE_NIBS - 1);
  localparam logic [11:0] IFG_LOAD = 12'(IFG_NIBS - 1);

  state_t      state, state_nxt;
  logic [11:0] cnt, cnt_nxt;
  logic [7:0]  crc, crc_nxt, crc_tx;
  logic [2:0]  type_q, type_nxt;
  logic [11:0] len_q, len_nxt;
  logic [3:0]  mtxd_q, mtxd_nxt, soc_nib;
  logic        mtxen_q, mtxen_nxt;
  logic        busy_q, done_q, done_nxt;
  logic        nib_rd;
  logic        inv_q;

  function automatic logic [7:0] crc8_nib(input logic [7:0] c, input logic [3:0] n);
    logic [7:0] r;
    r = c;
    for (int i = 3; i >= 0; i--) begin
      r = (r[7] ^ n[i]) ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    case (type_q)
      3'd1:    soc_nib = SOC_NUMB;
      3'd2:    soc_nib = SOC_DIST;
      3'd3:    soc_nib = SOC_DELAY;
      3'd4:    soc_nib = SOC_DELAYDIST;
      default: soc_nib = SOC_DATA;
    endcase
  end

`ifdef FB_TX_CRC_INJECT_EN
  logic inv_nxt;
  always_comb inv_nxt = (state == S_SOC && !bus.TxAbort) ? bus.TxCrcErr : inv_q;
  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) inv_q <= 1'b0;
    else       inv_q <= inv_nxt;
  end
`else
  assign inv_q = 1'b0;
`endif

  assign crc_tx = crc ^ {8{inv_q}};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    crc_nxt   = crc;
    type_nxt  = type_q;
    len_nxt   = len_q;
    mtxd_nxt  = 4'h0;
    mtxen_nxt = 1'b0;
    done_nxt  = 1'b0;
    nib_rd    = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.TxStart && !bus.TxAbort) begin
          state_nxt = S_PRE;
          cnt_nxt   = PRE_LOAD;
          crc_nxt   = 8'h00;
          type_nxt  = (bus.TxType > 3'd4) ? 3'd0 : bus.TxType;
          len_nxt   = bus.TxNibLen;
        end
      end
      S_PRE: begin
        mtxen_nxt = 1'b1;
        mtxd_nxt  = 4'h5;
        if (cnt == 12'd0) state_nxt = S_SOC;
        else              cnt_nxt   = cnt - 12'd1;
      end
      S_SOC: begin
        mtxen_nxt = 1'b1;
        mtxd_nxt  = soc_nib;
        crc_nxt   = crc8_nib(crc, soc_nib);
        // The counter arrives at Crc as 0 either way; bit 0 selects the CRC nibble.
        if (len_q != 12'd0) begin
          state_nxt = S_DATA;
          cnt_nxt   = len_q - 12'd1;
        end else begin
          state_nxt = S_CRC;
          cnt_nxt   = 12'd0;
        end
      end
      S_DATA: begin
        nib_rd    = 1'b1;
        mtxen_nxt = 1'b1;
        mtxd_nxt  = bus.TxData;
        crc_nxt   = crc8_nib(crc, bus.TxData);
        if (cnt == 12'd0) state_nxt = S_CRC;
        else              cnt_nxt   = cnt - 12'd1;
      end
      S_CRC: begin
        mtxen_nxt = 1'b1;
        if (!cnt[0]) begin
          mtxd_nxt = crc_tx[7:4];
          cnt_nxt  = 12'd1;
        end else begin
          mtxd_nxt  = crc_tx[3:0];
          state_nxt = S_IFG;
          cnt_nxt   = IFG_LOAD;
          done_nxt  = 1'b1;
        end
      end
      S_IFG: begin
        if (cnt == 12'd0) state_nxt = S_IDLE;
        else              cnt_nxt   = cnt - 12'd1;
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 12'd0;
      end
    endcase
    // Abort overrides everything outside Idle and restarts a full gap.
    if (state != S_IDLE && bus.TxAbort) begin
      state_nxt = S_IFG;
      cnt_nxt   = IFG_LOAD;
      crc_nxt   = crc;
      mtxd_nxt  = 4'h0;
      mtxen_nxt = 1'b0;
      done_nxt  = 1'b0;
      nib_rd    = 1'b0;
    end
  end

  always_ff @(posedge MRxClk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= 12'd0;
      crc     <= 8'h00;
      type_q  <= 3'd0;
      len_q   <= 12'd0;
      mtxd_q  <= 4'h0;
      mtxen_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      crc     <= crc_nxt;
      type_q  <= type_nxt;
      len_q   <= len_nxt;
      mtxd_q  <= mtxd_nxt;
      mtxen_q <= mtxen_nxt;
      busy_q  <= (state_nxt != S_IDLE);
      done_q  <= done_nxt;
    end
  end

  assign bus.TxNibRd   = nib_rd;
  assign bus.MTxD      = mtxd_q;
  assign bus.MTxEn     = mtxen_q;
  assign bus.TxBusy    = busy_q;
  assign bus.TxDone    = done_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_fb_slave_tx_statem.sv
// Bench for fb_slave_tx_statem: table of frame vectors against a bit-serial CRC-8 model,
// plus hand-written abort, start+abort, mid-frame reset and (FB_TX_CRC_INJECT_EN) CRC injection.
module tb_fb_slave_tx_statem;
  logic MRxClk = 1'b0;
  logic Reset;

  fb_slave_tx_statem_if bus();

  fb_slave_tx_statem dut (
    .MRxClk (MRxClk),
    .Reset  (Reset),
    .bus    (bus)
  );

  always #5 MRxClk = ~MRxClk;

  typedef struct {
    logic [2:0]  typ;
    logic [11:0] len;
    logic [3:0]  soc;
    logic        ramp;
  } vec_t;

  vec_t       vecs[9];
  logic [3:0] exp_q[$];
  logic [3:0] pay[4096];
  int         n_vec = 0;
  int         n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  function automatic logic [7:0] model_crc(input logic [7:0] c, input logic [3:0] n);
    logic fb;
    for (int b = 3; b >= 0; b--) begin
      fb = c[7] ^ n[b];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  // k counts negedges after the accepting edge; MTxEn must cover k = 1 .. 10+len.
  task automatic run_frame(input vec_t v, input logic err);
    logic [7:0] crc;
    int rd_cnt = 0, en_cnt = 0, done_cnt = 0, done_k = -1, first_en = -1, busy_low = -1, idle_bad = 0;
    int total;
    total = 10 + int'(v.len);
    crc = 8'h00;
    exp_q.delete();
    repeat (7) exp_q.push_back(4'h5);
    exp_q.push_back(v.soc);
    crc = model_crc(crc, v.soc);
    for (int i = 0; i < int'(v.len); i++) begin
      pay[i] = v.ramp ? 4'(i + 1) : 4'($urandom_range(0, 15));
      exp_q.push_back(pay[i]);
      crc = model_crc(crc, pay[i]);
    end
    if (err) crc = ~crc;
    exp_q.push_back(crc[7:4]);
    exp_q.push_back(crc[3:0]);

    @(negedge MRxClk);
    bus.TxStart  = 1'b1;
    bus.TxType   = v.typ;
    bus.TxNibLen = v.len;
`ifdef FB_TX_CRC_INJECT_EN
    bus.TxCrcErr = err;
`endif
    for (int k = 0; k < int'(v.len) + 40; k++) begin
      @(negedge MRxClk);
      if (k == 0) begin
        bus.TxStart  = 1'b0;
        bus.TxType   = 3'($urandom_range(0, 7));
        bus.TxNibLen = 12'($urandom_range(0, 4095));
      end
      if (bus.MTxEn) begin
        en_cnt++;
        if (first_en < 0) first_en = k;
        if (exp_q.size() > 0) check("mtxd", bus.MTxD, exp_q.pop_front());
        else                  check("mtxd_overrun", en_cnt, total);
      end else if (bus.MTxD !== 4'h0) begin
        idle_bad++;
      end
      if (bus.TxDone) begin
        done_cnt++;
        done_k = k;
      end
      if (bus.TxNibRd) begin
        if (rd_cnt < 4096) bus.TxData = pay[rd_cnt];
        rd_cnt++;
      end
      if (!bus.TxBusy) begin
        busy_low = k;
        break;
      end
    end
`ifdef FB_TX_CRC_INJECT_EN
    bus.TxCrcErr = 1'b0;
`endif
    check("first_mtxen_cycle", first_en, 1);
    check("mtxen_cycles", en_cnt, total);
    check("queue_drained", exp_q.size(), 0);
    check("txnibrd_cycles", rd_cnt, int'(v.len));
    check("txdone_pulses", done_cnt, 1);
    check("txdone_cycle", done_k, total);
    check("txbusy_fall_cycle", busy_low, total + 4);
    check("mtxd_zero_when_idle", idle_bad, 0);
  endtask

  initial begin
    int rd, en, busy, done_cnt, busy_low, hit;

    vecs[0] = '{3'd0, 12'd0,    4'hD, 1'b0};
    vecs[1] = '{3'd1, 12'd4,    4'h9, 1'b1};
    vecs[2] = '{3'd2, 12'd1,    4'hB, 1'b0};
    vecs[3] = '{3'd3, 12'd7,    4'h7, 1'b0};
    vecs[4] = '{3'd4, 12'd16,   4'h3, 1'b0};
    vecs[5] = '{3'd5, 12'd2,    4'hD, 1'b0};
    vecs[6] = '{3'd7, 12'd3,    4'hD, 1'b0};
    vecs[7] = '{3'd6, 12'd0,    4'hD, 1'b0};
    vecs[8] = '{3'd1, 12'd4095, 4'h9, 1'b0};

    Reset        = 1'b1;
    bus.TxStart  = 1'b0;
    bus.TxType   = 3'd0;
    bus.TxNibLen = 12'd0;
    bus.TxAbort  = 1'b0;
    bus.TxData   = 4'h0;
`ifdef FB_TX_CRC_INJECT_EN
    bus.TxCrcErr = 1'b0;
`endif
    repeat (3) @(negedge MRxClk);
    check("reset_mtxen", bus.MTxEn, 0);
    check("reset_mtxd", bus.MTxD, 0);
    check("reset_txbusy", bus.TxBusy, 0);
    check("reset_txdone", bus.TxDone, 0);
    check("reset_txnibrd", bus.TxNibRd, 0);
    Reset = 1'b0;

    for (int i = 0; i < 9; i++) run_frame(vecs[i], 1'b0);

    // Abort on the second payload nibble of a 16-nibble frame; a start during the gap is dropped.
    @(negedge MRxClk);
    bus.TxStart = 1'b1; bus.TxType = 3'd0; bus.TxNibLen = 12'd16;
    rd = 0; hit = 0; done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge MRxClk);
      if (k == 0) bus.TxStart = 1'b0;
      if (bus.TxDone) done_cnt++;
      if (bus.TxNibRd) begin
        rd++;
        if (rd == 2) begin
          check("mtxen_before_abort", bus.MTxEn, 1);
          bus.TxAbort = 1'b1;
          #1;
          check("abort_forces_nibrd_low", bus.TxNibRd, 0);
          hit = 1;
          break;
        end
        bus.TxData = 4'($urandom_range(0, 15));
      end
    end
    check("abort_reached_data", hit, 1);
    @(negedge MRxClk);
    bus.TxAbort = 1'b0;
    check("abort_mtxen", bus.MTxEn, 0);
    check("abort_mtxd", bus.MTxD, 0);
    check("abort_busy", bus.TxBusy, 1);
    en = 0; busy = 0; busy_low = -1;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) @(negedge MRxClk);
      if (k == 1) bus.TxStart = 1'b1;
      if (k == 2) bus.TxStart = 1'b0;
      if (bus.TxDone) done_cnt++;
      if (bus.MTxEn) en++;
      if (!bus.TxBusy && busy_low < 0) busy_low = k;
      if (bus.TxBusy && busy_low >= 0) busy++;
    end
    check("abort_no_txdone", done_cnt, 0);
    check("abort_ifg_mtxen", en, 0);
    check("abort_busy_fall_cycle", busy_low, 4);
    check("ifg_start_not_queued", busy, 0);

    // Start and abort together in Idle.
    @(negedge MRxClk);
    bus.TxStart = 1'b1; bus.TxAbort = 1'b1; bus.TxType = 3'd0; bus.TxNibLen = 12'd0;
    en = 0; busy = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge MRxClk);
      if (k == 0) begin
        bus.TxStart = 1'b0;
        bus.TxAbort = 1'b0;
      end
      if (bus.MTxEn) en++;
      if (bus.TxBusy) busy++;
    end
    check("start_abort_mtxen", en, 0);
    check("start_abort_busy", busy, 0);

    // Asynchronous reset in the middle of the payload.
    @(negedge MRxClk);
    bus.TxStart = 1'b1; bus.TxType = 3'd2; bus.TxNibLen = 12'd16;
    rd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge MRxClk);
      if (k == 0) bus.TxStart = 1'b0;
      if (bus.TxNibRd) begin
        rd++;
        bus.TxData = 4'($urandom_range(0, 15));
        if (rd == 3) break;
      end
    end
    check("reset_reached_data", rd, 3);
    Reset = 1'b1;
    #1;
    check("midreset_mtxen", bus.MTxEn, 0);
    check("midreset_txbusy", bus.TxBusy, 0);
    check("midreset_mtxd", bus.MTxD, 0);
    check("midreset_txnibrd", bus.TxNibRd, 0);
    @(negedge MRxClk);
    Reset = 1'b0;
    run_frame(vecs[0], 1'b0);

`ifdef FB_TX_CRC_INJECT_EN
    run_frame(vecs[0], 1'b1);
    run_frame(vecs[4], 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $fatal(1);
  end
endmodule
